// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the pipeline stage latches and the hazard unit.
// master = pipeline side (publishes latch contents, consumes stage controls),
// slave  = hazard_ctrl side.
// Optional macro HAZARD_PERF_EN adds the stall/flush performance counters.
interface hazard_ctrl_if;
    // IF/ID latch view
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    // ID/EX latch view
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_rd_memory;
    logic        ex_branch_taken;
    // EX/MEM and MEM/WB writeback view
    logic [4:0]  mem_rd;
    logic        mem_save_to_reg;
    logic [4:0]  wb_rd;
    logic        wb_save_to_reg;
    // data-memory handshake
    logic        dmem_req;
    logic        dmem_ack;
    // stage controls back to the latches
    logic        pc_ena;
    logic        ifid_ena;
    logic        idex_ena;
    logic        exmem_ena;
    logic        memwb_ena;
    logic        ifid_x;
    logic        idex_x;
    // EX operand forwarding selects
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rs1, ex_rs2, ex_rd, ex_rd_memory, ex_branch_taken,
        output mem_rd, mem_save_to_reg, wb_rd, wb_save_to_reg,
        output dmem_req, dmem_ack,
        input  pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
        input  ifid_x, idex_x,
        input  fwd_a_sel, fwd_b_sel
`ifdef HAZARD_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rs1, ex_rs2, ex_rd, ex_rd_memory, ex_branch_taken,
        input  mem_rd, mem_save_to_reg, wb_rd, wb_save_to_reg,
        input  dmem_req, dmem_ack,
        output pc_ena, ifid_ena, idex_ena, exmem_ena, memwb_ena,
        output ifid_x, idex_x,
        output fwd_a_sel, fwd_b_sel
`ifdef HAZARD_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stage-enable / bubble / flush control and EX operand forwarding
// for the 5-stage RV32I pipe. Load-use hazards insert LOAD_BUBBLES bubbles,
// taken branches squash IF/ID and ID/EX, data-memory waits freeze the pipe.
// Optional macro HAZARD_PERF_EN adds 32-bit stall_cnt / flush_cnt counters.
module hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic         stg_clk,
    input  logic         reset_n,
    hazard_ctrl_if.slave hz
);

    // Value loaded into the bubble counter when a load-use hit is taken.
    localparam logic [1:0] BCNT_LOAD    = 2'(LOAD_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_BUBBLES > 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_bcnt;
    logic [1:0] w_bcnt_next;

    logic       w_lu;
    logic       w_mw;
    logic       w_rs1_hit;
    logic       w_rs2_hit;

    logic       w_pc_ena;
    logic       w_ifid_ena;
    logic       w_idex_ena;
    logic       w_exmem_ena;
    logic       w_memwb_ena;
    logic       w_ifid_x;
    logic       w_idex_x;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_rs1_hit = hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd);
    assign w_rs2_hit = hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd);
    // A load into x0 never produces a value, so it cannot cause a hazard.
    assign w_lu      = hz.ex_rd_memory && (hz.ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_mw      = hz.dmem_req && !hz.dmem_ack;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State and bubble-counter register; reset abandons outstanding bubbles.
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_bcnt  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
        end
    end

    // Next-state and next bubble count.
    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        case (r_state)
            ST_RUN: begin
                if (w_mw) begin
                    w_state_next = ST_MWAIT;
                end else if (hz.ex_branch_taken) begin
                    // branch squashes the younger instruction: no bubble
                    w_state_next = ST_RUN;
                end else if (w_lu) begin
                    w_bcnt_next = BCNT_LOAD;
                    if (MULTI_BUBBLE) begin
                        w_state_next = ST_LSTALL;
                    end
                end
            end
            ST_LSTALL: begin
                // a memory wait freezes the bubble sequence in place
                if (!w_mw) begin
                    w_bcnt_next = r_bcnt - 2'd1;
                    if (r_bcnt <= 2'd1) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_MWAIT: begin
                if (hz.dmem_ack) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_bcnt_next  = 2'd0;
            end
        endcase
    end

    // Stage enables and bubble inserts; forced to free-run while in reset.
    always_comb begin
        w_pc_ena    = 1'b1;
        w_ifid_ena  = 1'b1;
        w_idex_ena  = 1'b1;
        w_exmem_ena = 1'b1;
        w_memwb_ena = 1'b1;
        w_ifid_x    = 1'b0;
        w_idex_x    = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mw) begin
                        w_pc_ena    = 1'b0;
                        w_ifid_ena  = 1'b0;
                        w_idex_ena  = 1'b0;
                        w_exmem_ena = 1'b0;
                        w_memwb_ena = 1'b0;
                    end else if (hz.ex_branch_taken) begin
                        w_ifid_x = 1'b1;
                        w_idex_x = 1'b1;
                    end else if (w_lu) begin
                        w_pc_ena   = 1'b0;
                        w_ifid_ena = 1'b0;
                        w_idex_x   = 1'b1;
                    end
                end
                ST_LSTALL: begin
                    if (w_mw) begin
                        w_pc_ena    = 1'b0;
                        w_ifid_ena  = 1'b0;
                        w_idex_ena  = 1'b0;
                        w_exmem_ena = 1'b0;
                        w_memwb_ena = 1'b0;
                    end else begin
                        w_pc_ena   = 1'b0;
                        w_ifid_ena = 1'b0;
                        w_idex_x   = 1'b1;
                    end
                end
                ST_MWAIT: begin
                    if (!hz.dmem_ack) begin
                        w_pc_ena    = 1'b0;
                        w_ifid_ena  = 1'b0;
                        w_idex_ena  = 1'b0;
                        w_exmem_ena = 1'b0;
                        w_memwb_ena = 1'b0;
                    end
                end
                default: begin
                    w_pc_ena = 1'b1;
                end
            endcase
        end
    end

    assign hz.pc_ena    = w_pc_ena;
    assign hz.ifid_ena  = w_ifid_ena;
    assign hz.idex_ena  = w_idex_ena;
    assign hz.exmem_ena = w_exmem_ena;
    assign hz.memwb_ena = w_memwb_ena;
    assign hz.ifid_x    = w_ifid_x;
    assign hz.idex_x    = w_idex_x;

    // ------------------------------------------------------------------
    // Operand forwarding: operand 0 = A (ex_rs1), operand 1 = B (ex_rs2).
    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never
    // forwarded because its architectural value is always zero.
    // ------------------------------------------------------------------
    logic [4:0] w_src_rs  [2];
    logic [1:0] w_fwd_sel [2];

    assign w_src_rs[0] = hz.ex_rs1;
    assign w_src_rs[1] = hz.ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic w_mem_hit;
            logic w_wb_hit;
            assign w_mem_hit = hz.mem_save_to_reg && (hz.mem_rd != 5'd0)
                               && (hz.mem_rd == w_src_rs[gi]);
            assign w_wb_hit  = hz.wb_save_to_reg && (hz.wb_rd != 5'd0)
                               && (hz.wb_rd == w_src_rs[gi]);
            assign w_fwd_sel[gi] = w_mem_hit ? 2'b01 :
                                   w_wb_hit  ? 2'b10 : 2'b00;
        end
    endgenerate

    assign hz.fwd_a_sel = w_fwd_sel[0];
    assign hz.fwd_b_sel = w_fwd_sel[1];

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-wrapping)
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_flush;

    assign w_flush = (r_state == ST_RUN) && !w_mw && hz.ex_branch_taken;

    // Count stalled PC cycles and branch flushes.
    always_ff @(posedge stg_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!w_pc_ena) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: drives identical stimulus into two hazard_ctrl instances
// (LOAD_BUBBLES = 1 and 3) and checks them against a cycle-level reference
// model that tracks "cycles of bubbles still owed" and "waiting on memory".
module tb_hazard_ctrl;

    logic stg_clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 stg_clk = ~stg_clk;

    hazard_ctrl_if if1 ();
    hazard_ctrl_if if3 ();

    hazard_ctrl #(.LOAD_BUBBLES(1)) u_dut1 (
        .stg_clk (stg_clk),
        .reset_n (reset_n),
        .hz      (if1.slave)
    );

    hazard_ctrl #(.LOAD_BUBBLES(3)) u_dut3 (
        .stg_clk (stg_clk),
        .reset_n (reset_n),
        .hz      (if3.slave)
    );

    // control vector {pc, ifid, idex, exmem, memwb, ifid_x, idex_x}
    localparam logic [6:0] C_RUN   = 7'b11111_00;
    localparam logic [6:0] C_FRZ   = 7'b00000_00;
    localparam logic [6:0] C_FLUSH = 7'b11111_11;
    localparam logic [6:0] C_BUB   = 7'b00111_01;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus
    logic [4:0] s_id_rs1, s_id_rs2, s_ex_rs1, s_ex_rs2, s_ex_rd, s_mem_rd, s_wb_rd;
    logic       s_rs1_used, s_rs2_used, s_ld, s_br, s_mem_we, s_wb_we, s_req, s_ack;

    // reference model state, index 0 -> LOAD_BUBBLES=1, 1 -> LOAD_BUBBLES=3
    int          lb       [2] = '{1, 3};
    int          m_owed   [2];
    bit          m_wait   [2];
    logic [31:0] m_stall  [2];
    logic [31:0] m_flush  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_id_rs1 = 5'd0; s_id_rs2 = 5'd0; s_rs1_used = 1'b0; s_rs2_used = 1'b0;
        s_ex_rs1 = 5'd0; s_ex_rs2 = 5'd0; s_ex_rd = 5'd0; s_ld = 1'b0; s_br = 1'b0;
        s_mem_rd = 5'd0; s_mem_we = 1'b0; s_wb_rd = 5'd0; s_wb_we = 1'b0;
        s_req = 1'b0; s_ack = 1'b0;
    endtask

    task automatic drive();
        if1.id_rs1 = s_id_rs1; if1.id_rs2 = s_id_rs2;
        if1.id_rs1_used = s_rs1_used; if1.id_rs2_used = s_rs2_used;
        if1.ex_rs1 = s_ex_rs1; if1.ex_rs2 = s_ex_rs2; if1.ex_rd = s_ex_rd;
        if1.ex_rd_memory = s_ld; if1.ex_branch_taken = s_br;
        if1.mem_rd = s_mem_rd; if1.mem_save_to_reg = s_mem_we;
        if1.wb_rd = s_wb_rd; if1.wb_save_to_reg = s_wb_we;
        if1.dmem_req = s_req; if1.dmem_ack = s_ack;
        if3.id_rs1 = s_id_rs1; if3.id_rs2 = s_id_rs2;
        if3.id_rs1_used = s_rs1_used; if3.id_rs2_used = s_rs2_used;
        if3.ex_rs1 = s_ex_rs1; if3.ex_rs2 = s_ex_rs2; if3.ex_rd = s_ex_rd;
        if3.ex_rd_memory = s_ld; if3.ex_branch_taken = s_br;
        if3.mem_rd = s_mem_rd; if3.mem_save_to_reg = s_mem_we;
        if3.wb_rd = s_wb_rd; if3.wb_save_to_reg = s_wb_we;
        if3.dmem_req = s_req; if3.dmem_ack = s_ack;
    endtask

    // Which pipeline stage supplies an EX operand.
    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (s_mem_we && s_mem_rd == rs) return 2'b01;
        if (s_wb_we && s_wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    // Apply current stimulus for one cycle, compare, advance the model.
    task automatic cycle(input string tag);
        bit          lu;
        bit          mw;
        logic [6:0]  exp;
        logic [6:0]  obs;
        drive();
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_owed[k] = 0; m_wait[k] = 1'b0; m_stall[k] = 32'd0; m_flush[k] = 32'd0;
            end
        end
        #1;
        lu = s_ld && (s_ex_rd != 5'd0) &&
             ((s_rs1_used && s_id_rs1 == s_ex_rd) || (s_rs2_used && s_id_rs2 == s_ex_rd));
        mw = s_req && !s_ack;
        for (int k = 0; k < 2; k++) begin
            exp = C_RUN;
            if (!reset_n) begin
                exp = C_RUN;
            end else if (m_wait[k]) begin
                if (s_ack) m_wait[k] = 1'b0;
                else       exp = C_FRZ;
            end else if (m_owed[k] > 0) begin
                if (mw) exp = C_FRZ;
                else begin exp = C_BUB; m_owed[k]--; end
            end else if (mw) begin
                exp = C_FRZ; m_wait[k] = 1'b1;
            end else if (s_br) begin
                exp = C_FLUSH;
            end else if (lu) begin
                exp = C_BUB; m_owed[k] = lb[k] - 1;
            end
            if (k == 0)
                obs = {if1.pc_ena, if1.ifid_ena, if1.idex_ena, if1.exmem_ena,
                       if1.memwb_ena, if1.ifid_x, if1.idex_x};
            else
                obs = {if3.pc_ena, if3.ifid_ena, if3.idex_ena, if3.exmem_ena,
                       if3.memwb_ena, if3.ifid_x, if3.idex_x};
            check($sformatf("%s/lb%0d/ctrl", tag, lb[k]), 32'(obs), 32'(exp));
`ifdef HAZARD_PERF_EN
            check($sformatf("%s/lb%0d/stall_cnt", tag, lb[k]),
                  (k == 0) ? if1.stall_cnt : if3.stall_cnt, m_stall[k]);
            check($sformatf("%s/lb%0d/flush_cnt", tag, lb[k]),
                  (k == 0) ? if1.flush_cnt : if3.flush_cnt, m_flush[k]);
`endif
            if (reset_n && !exp[6]) m_stall[k] = m_stall[k] + 32'd1;
            if (reset_n && exp == C_FLUSH) m_flush[k] = m_flush[k] + 32'd1;
        end
        check({tag, "/lb1/fwd_a"}, 32'(if1.fwd_a_sel), 32'(fwd_ref(s_ex_rs1)));
        check({tag, "/lb1/fwd_b"}, 32'(if1.fwd_b_sel), 32'(fwd_ref(s_ex_rs2)));
        check({tag, "/lb3/fwd_a"}, 32'(if3.fwd_a_sel), 32'(fwd_ref(s_ex_rs1)));
        check({tag, "/lb3/fwd_b"}, 32'(if3.fwd_b_sel), 32'(fwd_ref(s_ex_rs2)));
        $display("[TB] %s lu=%0d mw=%0d br=%0d ctrl1=%b ctrl3=%b fwd=%b/%b",
                 tag, lu, mw, s_br,
                 {if1.pc_ena, if1.ifid_ena, if1.idex_ena, if1.exmem_ena, if1.memwb_ena, if1.ifid_x, if1.idex_x},
                 {if3.pc_ena, if3.ifid_ena, if3.idex_ena, if3.exmem_ena, if3.memwb_ena, if3.ifid_x, if3.idex_x},
                 if1.fwd_a_sel, if1.fwd_b_sel);
        @(posedge stg_clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_owed[k] = 0; m_wait[k] = 1'b0; m_stall[k] = 32'd0; m_flush[k] = 32'd0;
        end
        // reset held with a memory wait and branch pending: pipe must free-run
        idle();
        reset_n = 1'b0;
        s_req = 1'b1; s_br = 1'b1;
        cycle("reset");
        idle();
        cycle("reset2");
        reset_n = 1'b1;
        cycle("idle");

        // load x5 in EX, ID add x6,x5,x1
        s_ld = 1'b1; s_ex_rd = 5'd5; s_id_rs1 = 5'd5; s_rs1_used = 1'b1;
        s_id_rs2 = 5'd1; s_rs2_used = 1'b1;
        cycle("lu");
        s_ld = 1'b0; s_ex_rd = 5'd0;
        for (int i = 0; i < 4; i++) cycle("lu_after");

        // load into x0 is harmless
        s_ld = 1'b1; s_ex_rd = 5'd0; s_id_rs1 = 5'd0;
        cycle("lu_x0");

        // branch and load-use together: branch wins
        s_ex_rd = 5'd5; s_id_rs1 = 5'd5; s_br = 1'b1;
        cycle("br_lu");
        idle();
        for (int i = 0; i < 2; i++) cycle("br_after");

        // memory wait: four cycles without ack, then ack
        s_req = 1'b1;
        for (int i = 0; i < 4; i++) cycle("mwait");
        s_ack = 1'b1;
        cycle("mack");
        idle();
        cycle("mdone");

        // forwarding priorities
        s_ex_rs1 = 5'd7; s_mem_rd = 5'd7; s_wb_rd = 5'd7; s_mem_we = 1'b1; s_wb_we = 1'b1;
        s_ex_rs2 = 5'd9;
        cycle("fwd_mem");
        s_mem_we = 1'b0; s_ex_rs2 = 5'd7;
        cycle("fwd_wb");
        s_ex_rs1 = 5'd0; s_mem_rd = 5'd0; s_wb_rd = 5'd0; s_mem_we = 1'b1;
        cycle("fwd_x0");
        idle();

        // reset dropped while LOAD_BUBBLES=3 instance is mid-stall
        s_ld = 1'b1; s_ex_rd = 5'd4; s_id_rs2 = 5'd4; s_rs2_used = 1'b1;
        cycle("lu_pre_rst");
        idle();
        reset_n = 1'b0;
        cycle("rst_mid");
        reset_n = 1'b1;
        cycle("rst_after");

        // randomized traffic with small register space to provoke hits
        for (int i = 0; i < 600; i++) begin
            reset_n    = ($urandom_range(0, 79) != 0);
            s_id_rs1   = 5'($urandom_range(0, 3));
            s_id_rs2   = 5'($urandom_range(0, 3));
            s_rs1_used = 1'($urandom_range(0, 1));
            s_rs2_used = 1'($urandom_range(0, 1));
            s_ex_rs1   = 5'($urandom_range(0, 3));
            s_ex_rs2   = 5'($urandom_range(0, 3));
            s_ex_rd    = 5'($urandom_range(0, 3));
            s_ld       = ($urandom_range(0, 2) == 0);
            s_br       = ($urandom_range(0, 7) == 0);
            s_mem_rd   = 5'($urandom_range(0, 3));
            s_mem_we   = 1'($urandom_range(0, 1));
            s_wb_rd    = 5'($urandom_range(0, 3));
            s_wb_we    = 1'($urandom_range(0, 1));
            s_req      = ($urandom_range(0, 3) == 0);
            s_ack      = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
